// File: rtl/lc3b_instr_encoder_if.sv
// Request/memory bundle for the LC-3b instruction encoder.
// master: field source and memory model; slave: the encoder itself.
interface lc3b_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [4:0]  imm5;
  logic        imm5_enable;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] imm11;
  logic        imm11_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;

  modport master (
    output req_valid, opcode, dest, src1, src2, imm5, imm5_enable,
           offset6, offset9, imm11, imm11_enable, mem_resp,
    input  req_ready, mem_address, mem_wdata, mem_write, mem_byte_enable
  );

  modport slave (
    input  req_valid, opcode, dest, src1, src2, imm5, imm5_enable,
           offset6, offset9, imm11, imm11_enable, mem_resp,
    output req_ready, mem_address, mem_wdata, mem_write, mem_byte_enable
  );
endinterface

// File: rtl/lc3b_instr_encoder.sv
// Packs LC-3b instruction fields into 16-bit words and writes them to
// sequential word addresses, one write in flight at a time.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | ready for a field bundle; restart reloads the pointer
// S_WRITE | mem_write held with stable address/data until mem_resp
module lc3b_instr_encoder #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_STEP = 16'd2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_restart,
  lc3b_instr_encoder_if.slave         bus,
  output logic [15:0]                 o_last_word,
  output logic [15:0]                 o_words_written,
  output logic                        o_busy
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_last_word;
  logic [15:0] r_count;
  logic [15:0] w_word;
  logic        w_accept;
  logic        w_done;

  // Field packing, evaluated every cycle and captured only on accept.
  always_comb begin
    w_word = 16'h0000;
    case (bus.opcode)
      4'b0001, 4'b0101:
        w_word = {bus.opcode, bus.dest, bus.src1, bus.imm5_enable,
                  bus.imm5_enable ? bus.imm5 : {2'b00, bus.src2}};
      4'b1001:
        w_word = {bus.opcode, bus.dest, bus.src1, 6'b111111};
      4'b0000, 4'b1110, 4'b1010, 4'b1011:
        w_word = {bus.opcode, bus.dest, bus.offset9};
      4'b0110, 4'b0111, 4'b0010, 4'b0011:
        w_word = {bus.opcode, bus.dest, bus.src1, bus.offset6};
      4'b1100:
        w_word = {bus.opcode, 3'b000, bus.src1, 6'b000000};
      4'b0100:
        w_word = {bus.opcode, bus.imm11_enable,
                  bus.imm11_enable ? bus.imm11 : {2'b00, bus.src1, 6'b000000}};
      4'b1101:
        w_word = {bus.opcode, bus.dest, bus.src1, bus.imm5_enable,
                  bus.imm5[4], bus.imm5[3:0]};
      4'b1111:
        w_word = {bus.opcode, 4'b0000, bus.imm11[7:0]};
      4'b1000:
        w_word = 16'h8000;
      default:
        w_word = 16'h0000;
    endcase
  end

  // Next-state and handshake/strobe outputs; outputs depend on state only,
  // so mem_write rises the cycle after accept and falls the cycle after resp.
  always_comb begin
    w_next_state        = r_state;
    w_accept            = 1'b0;
    w_done              = 1'b0;
    bus.req_ready       = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    o_busy              = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.mem_write       = 1'b1;
        bus.mem_byte_enable = 2'b11;
        o_busy              = 1'b1;
        if (bus.mem_resp) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Write pointer, data latch and completed-write counter. A restart in the
  // same cycle as an accept still lands the new word at BASE_ADDR because
  // the pointer only advances on completion.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr      <= BASE_ADDR;
      r_wdata     <= 16'h0000;
      r_last_word <= 16'h0000;
      r_count     <= 16'h0000;
    end else begin
      if (r_state == S_IDLE && i_restart) begin
        r_addr  <= BASE_ADDR;
        r_count <= 16'h0000;
      end
      if (w_accept) begin
        r_wdata     <= w_word;
        r_last_word <= w_word;
      end
      if (w_done) begin
        r_addr <= r_addr + ADDR_STEP;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.mem_address = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign o_last_word     = r_last_word;
  assign o_words_written = r_count;

endmodule
